display_packet_tx: RTL and testbench



---
 rtl/display_packet_tx.sv | 196 +++++++++++++++++++
 tb/tb_display_packet_tx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_packet_tx.sv
// Serial packet transmitter for the DisplayController link: two BCD digits go out as
// ASCII followed by a 0x00 terminator, each byte framed start/8 data LSB-first/even parity/stop.
module display_packet_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int IDLE_BITS    = 1
) (
    input  logic       clk1M8,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] digit_tens,
    input  logic [3:0] digit_units,
    output logic       serial,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int GAP_W = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IDLE_BITS > 0) ? (IDLE_BITS - 1) : 0);
    localparam bit HAS_GAP = (IDLE_BITS > 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        if (d <= 4'd9) begin
            return 8'h30 + {4'h0, d};
        end else begin
            return 8'h3F;
        end
    endfunction

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       units_q, units_d;
    logic             serial_q, serial_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;
    logic             frame_end;
    logic [7:0]       cur_byte;

    // Next-state, counters and registered line value
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = gap_cnt_q;
        tens_d     = tens_q;
        units_d    = units_q;
        done_d     = 1'b0;
        frame_end  = 1'b0;
        bit_end    = (clk_cnt_q == CNT_LAST);

        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
        end else begin
            clk_cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_START;
                    tens_d     = digit_tens;
                    units_d    = digit_units;
                    bit_idx_d  = 3'd0;
                    byte_idx_d = 2'd0;
                    gap_cnt_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_idx_q == 3'd7)) begin
                    state_d = S_PARITY;
                end else if (bit_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (bit_end && HAS_GAP) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end else if (bit_end) begin
                    frame_end = 1'b1;
                end else begin
                    state_d = S_STOP;
                end
            end
            S_GAP: begin
                if (bit_end && (gap_cnt_q == GAP_LAST)) begin
                    frame_end = 1'b1;
                end else if (bit_end) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end else begin
                    state_d = S_GAP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // End of one byte's frame plus idle gap: next byte or packet complete
        if (frame_end && (byte_idx_q < 2'd2)) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_START;
        end else if (frame_end) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end else begin
            done_d = 1'b0;
        end

        case (byte_idx_d)
            2'd0:    cur_byte = bcd_to_ascii(tens_d);
            2'd1:    cur_byte = bcd_to_ascii(units_d);
            default: cur_byte = 8'h00;
        endcase

        case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = cur_byte[bit_idx_d];
            S_PARITY: serial_d = even_parity(cur_byte);
            default:  serial_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk1M8 or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            gap_cnt_q  <= '0;
            tens_q     <= 4'd0;
            units_q    <= 4'd0;
            serial_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            tens_q     <= tens_d;
            units_q    <= units_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign serial = serial_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_display_packet_tx.sv
// Directed bench for display_packet_tx: default instance plus two parameter-sweep instances,
// each transmission captured cycle by cycle and decoded against hand-computed frames.
module tb_display_packet_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic [3:0] tens = 4'd0, units = 4'd0;
    logic       ser_a, busy_a, done_a;
    logic       ser_b, busy_b, done_b;
    logic       ser_c, busy_c, done_c;

    int errors = 0;
    int checks = 0;

    logic cap_ser  [0:799];
    logic cap_busy [0:799];
    logic cap_done [0:799];

    always #5 clk = ~clk;

    display_packet_tx u_a (
        .clk1M8(clk), .rst(rst), .start(start_a), .digit_tens(tens), .digit_units(units),
        .serial(ser_a), .busy(busy_a), .done(done_a));

    display_packet_tx #(.CLKS_PER_BIT(16), .IDLE_BITS(0)) u_b (
        .clk1M8(clk), .rst(rst), .start(start_b), .digit_tens(tens), .digit_units(units),
        .serial(ser_b), .busy(busy_b), .done(done_b));

    display_packet_tx #(.CLKS_PER_BIT(16), .IDLE_BITS(3)) u_c (
        .clk1M8(clk), .rst(rst), .start(start_c), .digit_tens(tens), .digit_units(units),
        .serial(ser_c), .busy(busy_c), .done(done_c));

    function automatic logic ser_of(input int w);
        case (w)
            0:       return ser_a;
            1:       return ser_b;
            default: return ser_c;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    // Pulse start at a falling edge; returns at the falling edge of the first start-bit cycle
    task automatic kick(input int w, input logic [3:0] t, input logic [3:0] u);
        tens  = t;
        units = u;
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        tens  = 4'hF;
        units = 4'hF;
    endtask

    // Record n cycles; optionally pulse start (with new digits) at cycle inj_at
    task automatic capture(input int w, input int n, input int inj_at,
                           input logic [3:0] it, input logic [3:0] iu);
        for (int k = 0; k < n; k++) begin
            if (k == inj_at + 1) begin
                set_start(w, 1'b0);
                tens  = 4'hE;
                units = 4'hE;
            end
            cap_ser[k]  = ser_of(w);
            cap_busy[k] = busy_of(w);
            cap_done[k] = done_of(w);
            if (k == inj_at) begin
                tens  = it;
                units = iu;
                set_start(w, 1'b1);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_packet(input string name, input int off, input int cpb, input int ib,
                                input logic [7:0] b0, input logic p0,
                                input logic [7:0] b1, input logic p1,
                                input logic [7:0] b2, input logic p2);
        int         stride;
        int         len;
        int         base;
        int         bad;
        int         bad_b;
        int         bad_d;
        logic       eb_bit;
        logic [7:0] eb [3];
        logic       ep [3];
        logic [7:0] dec;
        stride = 11 + ib;
        len    = 3 * stride * cpb;
        eb[0] = b0; eb[1] = b1; eb[2] = b2;
        ep[0] = p0; ep[1] = p1; ep[2] = p2;
        for (int b = 0; b < 3; b++) begin
            dec = 8'h00;
            for (int j = 0; j < stride; j++) begin
                base = off + (b * stride + j) * cpb;
                if (j == 0)       eb_bit = 1'b0;
                else if (j <= 8)  eb_bit = eb[b][j-1];
                else if (j == 9)  eb_bit = ep[b];
                else              eb_bit = 1'b1;
                bad = 0;
                for (int c = 0; c < cpb; c++) begin
                    if (cap_ser[base + c] !== eb_bit) bad++;
                end
                if (j >= 1 && j <= 8) dec[j-1] = cap_ser[base + cpb / 2];
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL %s byte%0d bit%0d: %0d of %0d cycles differ from required level %0b",
                             name, b, j, bad, cpb, eb_bit);
                end
            end
            checks++;
            if (dec !== eb[b]) begin
                errors++;
                $display("FAIL %s byte%0d decode: got %02h, required %02h", name, b, dec, eb[b]);
            end
        end
        bad_b = 0;
        bad_d = 0;
        for (int k = off; k <= off + len; k++) begin
            if (cap_busy[k] !== (k < off + len)) bad_b++;
            if (cap_done[k] !== (k == off + len)) bad_d++;
        end
        checks++;
        if (bad_d != 0) begin
            errors++;
            $display("FAIL %s done: %0d cycles wrong, required single pulse at cycle %0d",
                     name, bad_d, len);
        end
        checks++;
        if (bad_b != 0) begin
            errors++;
            $display("FAIL %s busy: %0d cycles wrong, required high for %0d cycles",
                     name, bad_b, len);
        end
    endtask

    task automatic check_idle(input string name, input int from, input int to);
        int bad;
        bad = 0;
        for (int k = from; k <= to; k++) begin
            if (cap_ser[k] !== 1'b1 || cap_busy[k] !== 1'b0 || cap_done[k] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s idle: %0d cycles not serial=1 busy=0 done=0", name, bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ser_a, busy_a, done_a} !== 3'b100) begin
            errors++;
            $display("FAIL reset_a: got ser/busy/done=%b, required 100", {ser_a, busy_a, done_a});
        end
        checks++;
        if ({ser_b, busy_b, done_b, ser_c, busy_c, done_c} !== 6'b100100) begin
            errors++;
            $display("FAIL reset_bc: got %b, required 100100",
                     {ser_b, busy_b, done_b, ser_c, busy_c, done_c});
        end
        rst = 1'b0;
        capture(0, 5, -1, 4'h0, 4'h0);
        check_idle("post_reset", 0, 4);
    endtask

    task automatic test_basic();
        kick(0, 4'd4, 4'd9);
        capture(0, 290, -1, 4'h0, 4'h0);
        check_packet("basic", 0, 8, 1, 8'h34, 1'b1, 8'h39, 1'b0, 8'h00, 1'b0);
        check_idle("basic_tail", 289, 289);
    endtask

    task automatic test_invalid_bcd();
        kick(0, 4'hA, 4'd0);
        capture(0, 290, -1, 4'h0, 4'h0);
        check_packet("invalid_bcd", 0, 8, 1, 8'h3F, 1'b0, 8'h30, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_busy_reject();
        kick(0, 4'd5, 4'd6);
        capture(0, 330, 50, 4'd1, 4'd2);
        check_packet("busy_reject", 0, 8, 1, 8'h35, 1'b0, 8'h36, 1'b0, 8'h00, 1'b0);
        check_idle("busy_reject_tail", 289, 329);
    endtask

    task automatic test_back_to_back();
        kick(0, 4'd2, 4'd3);
        capture(0, 580, 288, 4'd7, 4'd7);
        check_packet("b2b_first", 0, 8, 1, 8'h32, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
        check_packet("b2b_second", 289, 8, 1, 8'h37, 1'b1, 8'h37, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid();
        int bad;
        kick(0, 4'd4, 4'd9);
        repeat (120) @(negedge clk);
        checks++;
        if ({ser_a, busy_a} !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid_pre: got ser/busy=%b, required 01", {ser_a, busy_a});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ser_a, busy_a, done_a} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_async: got ser/busy/done=%b, required 100",
                     {ser_a, busy_a, done_a});
        end
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_a !== 1'b0) bad++;
        end
        rst = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_done: done high on %0d cycles, required 0", bad);
        end
        capture(0, 300, -1, 4'h0, 4'h0);
        check_idle("reset_mid_abandon", 0, 299);
        kick(0, 4'd8, 4'd1);
        capture(0, 290, -1, 4'h0, 4'h0);
        check_packet("reset_mid_restart", 0, 8, 1, 8'h38, 1'b1, 8'h31, 1'b1, 8'h00, 1'b0);
    endtask

    task automatic test_param_sweep();
        kick(1, 4'd0, 4'd5);
        capture(1, 530, -1, 4'h0, 4'h0);
        check_packet("cpb16_idle0", 0, 16, 0, 8'h30, 1'b0, 8'h35, 1'b0, 8'h00, 1'b0);
        check_idle("cpb16_idle0_tail", 529, 529);
        kick(2, 4'd9, 4'd6);
        capture(2, 674, -1, 4'h0, 4'h0);
        check_packet("cpb16_idle3", 0, 16, 3, 8'h39, 1'b0, 8'h36, 1'b0, 8'h00, 1'b0);
        check_idle("cpb16_idle3_tail", 673, 673);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid_bcd();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
